// File: rtl/b_opx_pkg.sv
// Shared types and constants for the operator keypad scanner.
package b_opx_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  localparam int unsigned OP_ADD = 0;
  localparam int unsigned OP_SUB = 1;
  localparam int unsigned OP_MUL = 2;
  localparam int unsigned OP_DIV = 3;
  localparam int unsigned OP_NOT = 4;
  localparam int unsigned OP_AND = 5;
  localparam int unsigned OP_OR  = 6;
  localparam int unsigned OP_XOR = 7;
  localparam int unsigned OP_LSR = 8;
  localparam int unsigned OP_LSL = 9;
  localparam int unsigned OP_ASR = 10;
  localparam int unsigned OP_ASL = 11;
  localparam int unsigned OP_NEG = 12;

  localparam logic [15:0] DEFAULT_VALID_MASK = 16'h0FFF;

  localparam int unsigned REPEAT_DELAY  = 32;
  localparam int unsigned REPEAT_PERIOD = 8;

endpackage

// File: rtl/b_opx_debounce.sv
// Stability counter: done_c fires on the CYCLES-th consecutive cycle with same high.
module b_opx_debounce
  import b_opx_pkg::*;
#(
  parameter int unsigned CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic same,
  output logic done_c
);

  localparam int unsigned CNT_W = $clog2(CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  assign done_c = same && (cnt == CNT_W'(CYCLES - 1));

  // Counter self-clears on done so it is ready for the next phase (press -> release).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (same && !done_c) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/b_opx_scan.sv
// Operator keypad scanner: one-cold column scan, debounce, keycode encode, sign flag.
// Optional auto-repeat of held operator keys when B_OPX_AUTO_REPEAT_EN is defined.
module b_opx_scan
  import b_opx_pkg::*;
#(
  parameter int unsigned ROWS            = 4,
  parameter int unsigned COLS            = 4,
  parameter int unsigned SCAN_DWELL      = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 2,
  parameter logic [ROWS*COLS-1:0] VALID_MASK = DEFAULT_VALID_MASK,
  parameter int unsigned NEG_KEY         = 12,
  localparam int unsigned KC_W           = $clog2(ROWS * COLS)
) (
  input  logic            i_sys_clock,
  input  logic            i_sys_reset,
  input  logic [ROWS-1:0] i_b_opx_keypad_row,
  input  logic            i_b_opx_hex_new_input,
  output logic [COLS-1:0] o_b_opx_keypad_column,
  output logic [KC_W-1:0] o_b_opx_keycode,
  output logic            o_b_opx_valid_key_pressed,
  output logic            o_b_opx_neg_flag,
  output logic            o_b_opx_key_held
);

  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned DW_W  = $clog2(SCAN_DWELL + 1);
  localparam logic [COLS-1:0] ONE_COL = COLS'(1);

  state_t           state;
  logic [COL_W-1:0] col_idx;
  logic [COL_W-1:0] col_nxt;
  logic [DW_W-1:0]  dwell;
  logic [ROW_W-1:0] lat_row;
  logic [ROW_W-1:0] low_idx;
  logic             any_low;
  logic             press_same;
  logic             db_same;
  logic             db_done;
  logic [KC_W-1:0]  key;

`ifdef B_OPX_AUTO_REPEAT_EN
  localparam int unsigned RPT_W = $clog2(REPEAT_DELAY);
  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_arm;
`endif

  // Lowest-index active-low row wins.
  always_comb begin
    low_idx = '0;
    any_low = 1'b0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (!i_b_opx_keypad_row[i]) begin
        low_idx = ROW_W'(i);
        any_low = 1'b1;
      end
    end
  end

  assign press_same = any_low && (low_idx == lat_row);
  assign col_nxt    = (col_idx == COL_W'(COLS - 1)) ? '0 : col_idx + COL_W'(1);
  assign key        = KC_W'(32'(col_idx) * ROWS + 32'(lat_row));

  // The one counter tracks press stability in DEBOUNCE and release stability in HELD.
  always_comb begin
    db_same = 1'b0;
    case (state)
      DEBOUNCE: db_same = press_same;
      HELD:     db_same = !any_low;
      default:  db_same = 1'b0;
    endcase
  end

  b_opx_debounce #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (i_sys_clock),
    .rst    (i_sys_reset),
    .same   (db_same),
    .done_c (db_done)
  );

  always_ff @(posedge i_sys_clock or posedge i_sys_reset) begin
    if (i_sys_reset) begin
      state                     <= SCAN;
      col_idx                   <= '0;
      dwell                     <= '0;
      lat_row                   <= '0;
      o_b_opx_keypad_column     <= ~ONE_COL;
      o_b_opx_keycode           <= '0;
      o_b_opx_valid_key_pressed <= 1'b0;
      o_b_opx_neg_flag          <= 1'b0;
      o_b_opx_key_held          <= 1'b0;
`ifdef B_OPX_AUTO_REPEAT_EN
      rpt_cnt                   <= '0;
      rpt_arm                   <= 1'b0;
`endif
    end else begin
      o_b_opx_valid_key_pressed <= 1'b0;
      case (state)
        SCAN: begin
          if (any_low) begin
            state   <= DEBOUNCE;
            lat_row <= low_idx;
            dwell   <= '0;
          end else if (dwell == DW_W'(SCAN_DWELL - 1)) begin
            dwell                 <= '0;
            col_idx               <= col_nxt;
            o_b_opx_keypad_column <= ~(ONE_COL << col_nxt);
          end else begin
            dwell <= dwell + DW_W'(1);
          end
        end
        DEBOUNCE: begin
          if (!press_same) begin
            state                 <= SCAN;
            dwell                 <= '0;
            col_idx               <= col_nxt;
            o_b_opx_keypad_column <= ~(ONE_COL << col_nxt);
          end else if (db_done) begin
            state            <= HELD;
            o_b_opx_key_held <= 1'b1;
`ifdef B_OPX_AUTO_REPEAT_EN
            rpt_cnt <= '0;
            rpt_arm <= 1'b0;
`endif
            if (key == KC_W'(NEG_KEY)) begin
              o_b_opx_neg_flag <= ~o_b_opx_neg_flag;
            end else if (VALID_MASK[key]) begin
              o_b_opx_keycode           <= key;
              o_b_opx_valid_key_pressed <= 1'b1;
`ifdef B_OPX_AUTO_REPEAT_EN
              rpt_arm <= 1'b1;
`endif
            end
          end
        end
        HELD: begin
`ifdef B_OPX_AUTO_REPEAT_EN
          // Repeats stop for good once the release count has started.
          if (!any_low) begin
            rpt_arm <= 1'b0;
          end else if (rpt_arm) begin
            if (rpt_cnt == RPT_W'(REPEAT_DELAY - 1)) begin
              o_b_opx_valid_key_pressed <= 1'b1;
              rpt_cnt <= RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);
            end else begin
              rpt_cnt <= rpt_cnt + RPT_W'(1);
            end
          end
`endif
          if (db_done) begin
            state                 <= SCAN;
            o_b_opx_key_held      <= 1'b0;
            dwell                 <= '0;
            col_idx               <= col_nxt;
            o_b_opx_keypad_column <= ~(ONE_COL << col_nxt);
          end
        end
        default: state <= SCAN;
      endcase
      // New operand digit clears the sign, overriding a same-cycle toggle.
      if (i_b_opx_hex_new_input) begin
        o_b_opx_neg_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_b_opx_scan.sv
// Directed self-checking bench for b_opx_scan (default parameters).
`timescale 1ns/1ps
module tb_b_opx_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row = 4'hF;
  logic       new_in = 1'b0;
  logic [3:0] column;
  logic [3:0] keycode;
  logic       valid;
  logic       neg;
  logic       held;

  int total = 0;
  int bad   = 0;

  b_opx_scan dut (
    .i_sys_clock               (clk),
    .i_sys_reset               (rst),
    .i_b_opx_keypad_row        (row),
    .i_b_opx_hex_new_input     (new_in),
    .o_b_opx_keypad_column     (column),
    .o_b_opx_keycode           (keycode),
    .o_b_opx_valid_key_pressed (valid),
    .o_b_opx_neg_flag          (neg),
    .o_b_opx_key_held          (held)
  );

  always #5 clk = ~clk;

  task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_col(input logic [3:0] target);
    int n = 0;
    while (column !== target && n < 16) begin
      @(negedge clk);
      n++;
    end
    check4("wait_col", column, target);
  endtask

  // Drive the key once its column is active; returns at the second negedge, key still down.
  task automatic press_key(input logic [3:0] col, input logic [3:0] rowv);
    wait_col(col);
    row = rowv;
    step();
    check4("frozen_col", column, col);
    check1("no_early_valid", valid, 1'b0);
    step();
    check1("valid_before_latency", valid, 1'b0);
  endtask

  task automatic release_key();
    row = 4'hF;
    step();
    check1("held_during_release", held, 1'b1);
    step();
    check1("held_cleared", held, 1'b0);
  endtask

  initial begin
    logic [3:0] e;

    // Reset state
    repeat (3) step();
    check4("rst_column", column, 4'b1110);
    check4("rst_keycode", keycode, 4'd0);
    check1("rst_valid", valid, 1'b0);
    check1("rst_neg", neg, 1'b0);
    check1("rst_held", held, 1'b0);
    rst = 1'b0;

    // 1: idle scan
    for (int k = 1; k <= 20; k++) begin
      step();
      e = ~(4'b0001 << (k % 4));
      check4("idle_column", column, e);
      check1("idle_valid", valid, 1'b0);
      check1("idle_neg", neg, 1'b0);
    end

    // 2: key 1 (SUB) at column 0, row 1
    press_key(4'b1110, 4'b1101);
    step();
    check1("sub_valid", valid, 1'b1);
    check4("sub_keycode", keycode, 4'd1);
    check1("sub_held", held, 1'b1);
    release_key();
    check4("sub_next_col", column, 4'b1101);

    // 3: NEG key toggles sign, new_input overrides toggle
    press_key(4'b0111, 4'b1110);
    step();
    check1("neg1_flag", neg, 1'b1);
    check1("neg1_valid", valid, 1'b0);
    check4("neg1_keycode", keycode, 4'd1);
    release_key();
    press_key(4'b0111, 4'b1110);
    step();
    check1("neg2_flag", neg, 1'b0);
    release_key();
    press_key(4'b0111, 4'b1110);
    new_in = 1'b1;
    step();
    new_in = 1'b0;
    check1("neg3_override", neg, 1'b0);
    check1("neg3_held", held, 1'b1);
    release_key();

    // 4: masked key 14
    press_key(4'b0111, 4'b1011);
    step();
    check1("mask_valid", valid, 1'b0);
    check4("mask_keycode", keycode, 4'd1);
    check1("mask_held", held, 1'b1);
    release_key();
    check4("mask_resume", column, 4'b1110);

    // Two rows low: lowest row wins -> key 9 (LSL)
    press_key(4'b1011, 4'b1001);
    step();
    check1("multi_valid", valid, 1'b1);
    check4("multi_keycode", keycode, 4'd9);
    release_key();

    // 5: one-cycle glitch, then real XOR press
    wait_col(4'b1101);
    row = 4'b0111;
    step();
    check4("glitch_frozen", column, 4'b1101);
    row = 4'hF;
    step();
    check4("glitch_resume", column, 4'b1011);
    check1("glitch_valid", valid, 1'b0);
    check1("glitch_held", held, 1'b0);
    press_key(4'b1101, 4'b0111);
    step();
    check1("xor_valid", valid, 1'b1);
    check4("xor_keycode", keycode, 4'd7);
    step();
    check1("xor_single_pulse", valid, 1'b0);
    step();
    check1("xor_no_repeat", valid, 1'b0);
    check1("xor_held", held, 1'b1);
    release_key();

    // 6: async reset while held with neg set
    press_key(4'b0111, 4'b1110);
    step();
    check1("pre_rst_neg", neg, 1'b1);
    check1("pre_rst_held", held, 1'b1);
    #2;
    rst = 1'b1;
    row = 4'hF;
    #1;
    check4("arst_column", column, 4'b1110);
    check4("arst_keycode", keycode, 4'd0);
    check1("arst_valid", valid, 1'b0);
    check1("arst_neg", neg, 1'b0);
    check1("arst_held", held, 1'b0);
    step();
    check4("arst_hold_column", column, 4'b1110);
    rst = 1'b0;
    step();
    check4("restart_column", column, 4'b1101);
    check1("restart_held", held, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
